// File: rtl/trap_return_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_return_ctrl_pkg
// Description : Shared types and constants for the trap entry/return
//               controller.
//               - Default widths.
//               - Exception code type.
//               - FSM state enum.
//               - CSR addresses and mstatus bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_return_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int EXP_CODE_W = 5;

    typedef logic [EXP_CODE_W-1:0] ExpCode_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } TrapState_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage
`default_nettype wire

// File: rtl/trap_csr_regs.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr_regs
// Description : Storage for mstatus.MIE/MPIE, mepc and mcause, with write
//               priority and the CSR read mux.
//               Write priority, highest first:
//               1. trap entry
//               2. mret
//               3. software CSR write
// Ports       : clk, reset_       - clock, async active-low reset
//               i_trap_take       - exception accepted this cycle
//               i_mret_take       - mret accepted this cycle
//               i_csr_wr          - CSR write accepted this cycle
//               i_exp_code/i_pc   - trap cause and faulting PC
//               i_csr_addr/wdata  - CSR access port
//               o_csr_rdata       - combinational read of i_csr_addr
//               o_mie, o_mepc     - current MIE and mepc
// Revision    : 1.0 - initial release
// ============================================================================
module trap_csr_regs
    import trap_return_ctrl_pkg::*;
#(
    parameter int ADDR = ADDR_WIDTH,
    parameter int DATA = DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            i_trap_take,
    input  logic            i_mret_take,
    input  logic            i_csr_wr,
    input  ExpCode_t        i_exp_code,
    input  logic [ADDR-1:0] i_pc,
    input  logic [11:0]     i_csr_addr,
    input  logic [DATA-1:0] i_csr_wdata,
    output logic [DATA-1:0] o_csr_rdata,
    output logic            o_mie,
    output logic [ADDR-1:0] o_mepc
);

    localparam logic [ADDR-1:0] c_ALIGN_MASK = ~ADDR'(3);

    logic            r_mie;
    logic            r_mpie;
    logic [ADDR-1:0] r_mepc;
    logic [DATA-1:0] r_mcause;
    logic [DATA-1:0] w_rdata;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else if (i_trap_take) begin
            r_mepc   <= i_pc & c_ALIGN_MASK;
            // Zero extension also clears the interrupt flag in bit DATA-1.
            r_mcause <= DATA'(i_exp_code);
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (i_mret_take) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
        end else if (i_csr_wr) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= i_csr_wdata[MSTATUS_MIE];
                    r_mpie <= i_csr_wdata[MSTATUS_MPIE];
                end
                CSR_MEPC:   r_mepc   <= ADDR'(i_csr_wdata) & c_ALIGN_MASK;
                CSR_MCAUSE: r_mcause <= i_csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                w_rdata[MSTATUS_MIE]  = r_mie;
                w_rdata[MSTATUS_MPIE] = r_mpie;
            end
            CSR_MEPC:   w_rdata = DATA'(r_mepc);
            CSR_MCAUSE: w_rdata = r_mcause;
            default:    w_rdata = '0;
        endcase
    end

    assign o_csr_rdata = w_rdata;
    assign o_mie       = r_mie;
    assign o_mepc      = r_mepc;

endmodule
`default_nettype wire

// File: rtl/trap_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_return_ctrl
// Description : Trap entry / mret controller beside the commit stage.
//               On an exception or mret it:
//               - updates the trap CSRs;
//               - pulses flush_;
//               - holds a fetch redirect until fetch accepts it.
// Ports       : clk, reset_                   - clock, async active-low reset
//               commit_exp_, commit_exp_code,
//               commit_pc                     - committed exception
//               commit_mret_                  - committed mret
//               exp_handler_pc                - trap handler target
//               csr_we_, csr_addr, csr_wdata,
//               csr_rdata                     - CSR access port
//               creg_exp_mask                 - interrupt mask (~MIE)
//               flush_                        - one-cycle flush pulse
//               redirect_valid_, redirect_pc,
//               redirect_ready                - fetch redirect handshake
//               busy                          - redirect outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module trap_return_ctrl
    import trap_return_ctrl_pkg::*;
#(
    parameter int ADDR = ADDR_WIDTH,
    parameter int DATA = DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            commit_exp_,
    input  ExpCode_t        commit_exp_code,
    input  logic [ADDR-1:0] commit_pc,
    input  logic            commit_mret_,
    input  logic [ADDR-1:0] exp_handler_pc,
    input  logic            csr_we_,
    input  logic [11:0]     csr_addr,
    input  logic [DATA-1:0] csr_wdata,
    output logic [DATA-1:0] csr_rdata,
    output logic            creg_exp_mask,
    output logic            flush_,
    output logic            redirect_valid_,
    output logic [ADDR-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    TrapState_t      r_state;
    TrapState_t      w_next_state;
    logic            w_take_exp;
    logic            w_take_mret;
    logic            w_csr_wr;
    logic            r_flush;
    logic [ADDR-1:0] r_redirect_pc;
    logic            w_mie;
    logic [ADDR-1:0] w_mepc;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Events and CSR writes are only honoured in IDLE.
    // An exception shadows a simultaneous mret.
    // Either event shadows a simultaneous CSR write.
    always_comb begin
        w_next_state = r_state;
        w_take_exp   = 1'b0;
        w_take_mret  = 1'b0;
        w_csr_wr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!commit_exp_) begin
                    w_take_exp   = 1'b1;
                    w_next_state = REDIRECT;
                end else if (!commit_mret_) begin
                    w_take_mret  = 1'b1;
                    w_next_state = REDIRECT;
                end else if (!csr_we_) begin
                    w_csr_wr     = 1'b1;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_take_exp | w_take_mret;
            if (w_take_exp) begin
                r_redirect_pc <= exp_handler_pc;
            end else if (w_take_mret) begin
                r_redirect_pc <= w_mepc;
            end
        end
    end

    trap_csr_regs #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_csr_regs (
        .clk         (clk),
        .reset_      (reset_),
        .i_trap_take (w_take_exp),
        .i_mret_take (w_take_mret),
        .i_csr_wr    (w_csr_wr),
        .i_exp_code  (commit_exp_code),
        .i_pc        (commit_pc),
        .i_csr_addr  (csr_addr),
        .i_csr_wdata (csr_wdata),
        .o_csr_rdata (csr_rdata),
        .o_mie       (w_mie),
        .o_mepc      (w_mepc)
    );

    assign flush_          = ~r_flush;
    assign redirect_valid_ = (r_state != REDIRECT);
    assign busy            = (r_state == REDIRECT);
    assign redirect_pc     = r_redirect_pc;
    assign creg_exp_mask   = ~w_mie;

endmodule
`default_nettype wire

// File: tb/tb_trap_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_return_ctrl
// Description : Self-checking bench for trap_return_ctrl.
//               Stimulus is applied in three parts:
//               - directed vector table;
//               - hand-written corner sequences;
//               - randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_return_ctrl;
    import trap_return_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        commit_exp_;
    ExpCode_t    commit_exp_code;
    logic [31:0] commit_pc;
    logic        commit_mret_;
    logic [31:0] exp_handler_pc;
    logic        csr_we_;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        creg_exp_mask;
    logic        flush_;
    logic        redirect_valid_;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    trap_return_ctrl #(.ADDR(32), .DATA(32)) dut (
        .clk             (clk),
        .reset_          (reset_),
        .commit_exp_     (commit_exp_),
        .commit_exp_code (commit_exp_code),
        .commit_pc       (commit_pc),
        .commit_mret_    (commit_mret_),
        .exp_handler_pc  (exp_handler_pc),
        .csr_we_         (csr_we_),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .creg_exp_mask   (creg_exp_mask),
        .flush_          (flush_),
        .redirect_valid_ (redirect_valid_),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Each row is applied for one cycle.
    // The expected fields describe the outputs observed during that cycle.
    typedef struct {
        logic        exp_n;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        mret_n;
        logic [31:0] hpc;
        logic        we_n;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        e_flush_n;
        logic        e_rv_n;
        logic [31:0] e_rpc;
        logic        e_busy;
        logic        e_mask;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic exp_n, input logic [4:0] code, input logic [31:0] pc,
                         input logic mret_n, input logic [31:0] hpc, input logic we_n,
                         input logic [11:0] addr, input logic [31:0] wdata, input logic ready);
        commit_exp_     = exp_n;
        commit_exp_code = code;
        commit_pc       = pc;
        commit_mret_    = mret_n;
        exp_handler_pc  = hpc;
        csr_we_         = we_n;
        csr_addr        = addr;
        csr_wdata       = wdata;
        redirect_ready  = ready;
    endtask

    task automatic idle_in(input logic [11:0] addr, input logic ready);
        drive(1'b1, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1, addr, 32'h0, ready);
    endtask

    task automatic check_outs(input string tag, input logic fl, input logic rv, input logic [31:0] rpc,
                              input logic bz, input logic mk, input logic [31:0] rd);
        chk({tag, ".flush_"}, {31'd0, flush_}, {31'd0, fl});
        chk({tag, ".redirect_valid_"}, {31'd0, redirect_valid_}, {31'd0, rv});
        chk({tag, ".redirect_pc"}, redirect_pc, rpc);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        chk({tag, ".creg_exp_mask"}, {31'd0, creg_exp_mask}, {31'd0, mk});
        chk({tag, ".csr_rdata"}, csr_rdata, rd);
    endtask

    // Reference model: architectural register values plus a pending-redirect flag.
    logic        m_mie, m_mpie, m_busy, m_flush;
    logic [31:0] m_mepc, m_mcause, m_rpc;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_busy = 0; m_flush = 0;
        m_mepc = 0; m_mcause = 0; m_rpc = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) * 32'd128) + (32'(m_mie) * 32'd8);
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        m_flush = 0;
        if (m_busy) begin
            if (redirect_ready) m_busy = 0;
        end else if (!commit_exp_) begin
            m_mepc   = commit_pc - (commit_pc % 4);
            m_mcause = 32'(commit_exp_code);
            m_mpie   = m_mie;
            m_mie    = 0;
            m_rpc    = exp_handler_pc;
            m_busy   = 1;
            m_flush  = 1;
        end else if (!commit_mret_) begin
            m_mie   = m_mpie;
            m_mpie  = 1;
            m_rpc   = m_mepc;
            m_busy  = 1;
            m_flush = 1;
        end else if (!csr_we_) begin
            if (csr_addr == 12'h300) begin
                m_mie  = csr_wdata[3];
                m_mpie = csr_wdata[7];
            end else if (csr_addr == 12'h341) begin
                m_mepc = csr_wdata - (csr_wdata % 4);
            end else if (csr_addr == 12'h342) begin
                m_mcause = csr_wdata;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        idle_in(12'h300, 1'b0);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
    endtask

    logic [11:0] addrs[5];

    initial begin
        reset_ = 1'b1;
        idle_in(12'h300, 1'b0);
        #2 reset_ = 1'b0;
        #1 check_outs("reset", 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;

        //              exp code pc        mret hpc        we   addr     wdata  rdy  fl rv rpc        bz mk rdata
        tbl[0]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h300, 32'h0,  0,   1, 1, 32'h0,    0, 1, 32'h0};
        tbl[1]  = '{1, 0, 32'h0,    1, 32'h0,    0, 12'h300, 32'h8,  0,   1, 1, 32'h0,    0, 1, 32'h0};
        tbl[2]  = '{0, 2, 32'h1006, 1, 32'h2000, 1, 12'h300, 32'h0,  0,   1, 1, 32'h0,    0, 0, 32'h8};
        tbl[3]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h341, 32'h0,  0,   0, 0, 32'h2000, 1, 1, 32'h1004};
        tbl[4]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h342, 32'h0,  0,   1, 0, 32'h2000, 1, 1, 32'h2};
        tbl[5]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h300, 32'h0,  0,   1, 0, 32'h2000, 1, 1, 32'h80};
        tbl[6]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h7C0, 32'h0,  1,   1, 0, 32'h2000, 1, 1, 32'h0};
        tbl[7]  = '{1, 0, 32'h0,    0, 32'h0,    1, 12'h300, 32'h0,  0,   1, 1, 32'h2000, 0, 1, 32'h80};
        tbl[8]  = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h300, 32'h0,  1,   0, 0, 32'h1004, 1, 0, 32'h88};
        tbl[9]  = '{0, 7, 32'h3008, 0, 32'h4000, 0, 12'h341, 32'h55, 0,   1, 1, 32'h1004, 0, 0, 32'h1004};
        tbl[10] = '{0, 9, 32'h5000, 1, 32'h6000, 1, 12'h341, 32'h0,  0,   0, 0, 32'h4000, 1, 1, 32'h3008};
        tbl[11] = '{1, 0, 32'h0,    1, 32'h0,    1, 12'h342, 32'h0,  0,   1, 0, 32'h4000, 1, 1, 32'h7};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].exp_n, tbl[i].code, tbl[i].pc, tbl[i].mret_n, tbl[i].hpc,
                  tbl[i].we_n, tbl[i].addr, tbl[i].wdata, tbl[i].ready);
            #1 check_outs($sformatf("vec%0d", i), tbl[i].e_flush_n, tbl[i].e_rv_n,
                          tbl[i].e_rpc, tbl[i].e_busy, tbl[i].e_mask, tbl[i].e_rdata);
        end

        // Reset in the middle of a redirect aborts it immediately.
        @(negedge clk);
        idle_in(12'h341, 1'b0);
        reset_ = 1'b0;
        #1 check_outs("rst_mid", 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // Redirect accepted in its first cycle; a new event is taken one cycle later.
        @(negedge clk);
        drive(1'b0, 5'd3, 32'h100, 1'b1, 32'h200, 1'b1, 12'h342, 32'h0, 1'b1);
        #1 chk("b2b.idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd4, 32'h300, 1'b1, 32'h400, 1'b1, 12'h342, 32'h0, 1'b1);
        #1 check_outs("b2b.redir", 1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h3);
        @(negedge clk);
        drive(1'b0, 5'd5, 32'h500, 1'b1, 32'h600, 1'b1, 12'h342, 32'h0, 1'b1);
        #1 check_outs("b2b.idle2", 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h3);
        @(negedge clk);
        idle_in(12'h342, 1'b1);
        #1 check_outs("b2b.redir2", 1'b0, 1'b0, 32'h600, 1'b1, 1'b1, 32'h5);

        // Randomized run against the reference model.
        addrs[0] = 12'h300; addrs[1] = 12'h341; addrs[2] = 12'h342;
        addrs[3] = 12'h7C0; addrs[4] = 12'h343;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 4) != 0, 5'($urandom), $urandom,
                  $urandom_range(0, 4) != 0, $urandom, $urandom_range(0, 1) != 0,
                  addrs[$urandom_range(0, 4)], $urandom, $urandom_range(0, 2) != 0);
            #1 check_outs($sformatf("rnd%0d", c), ~m_flush, ~m_busy, m_rpc, m_busy,
                          ~m_mie, model_read(csr_addr));
            @(posedge clk);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
